// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Requester identifiers and the round-robin pointer encoding live here.
package rf_write_arbiter_pkg;

    localparam int unsigned RF_XLEN = 32;
    localparam int unsigned RF_NREG = 32;
    localparam int unsigned RF_AW   = $clog2(RF_NREG);

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_WB,
        REQ_LD,
        REQ_DBG
    } req_e;

    // Names the requester that wins the next ld/dbg contention.
    typedef enum logic {
        RR_LD  = 1'b0,
        RR_DBG = 1'b1
    } rr_e;

    function automatic rr_e rr_next(input req_e grant, input rr_e cur);
        rr_e nxt;
        nxt = cur;
        if (grant == REQ_LD) begin
            nxt = RR_DBG;
        end else if (grant == REQ_DBG) begin
            nxt = RR_LD;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Load scoreboard: one busy bit per register with an outstanding load,
// the sticky WAW error flag and the decode RAW stall compare.
module rf_scoreboard
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned NREG = RF_NREG,
    parameter int unsigned AW   = RF_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_en,
    input  logic [AW-1:0]   set_idx,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_idx,
    input  logic [AW-1:0]   rs1,
    input  logic            rs1_used,
    input  logic [AW-1:0]   rs2,
    input  logic            rs2_used,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic            err_waw
);

    logic [NREG-1:0] busy_d, busy_q;
    logic            err_waw_d, err_waw_q;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        // Applied after the clear so a same-cycle re-issue keeps the bit set.
        if (set_en && (set_idx != '0)) begin
            busy_d[set_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
        err_waw_d = err_waw_q | (set_en & busy_q[set_idx]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            err_waw_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            err_waw_q <= err_waw_d;
        end
    end

    // No forwarding from the load return: only the registered busy view is used.
    always_comb begin
        stall = rst_n &
                ((rs1_used & (rs1 != '0) & busy_q[rs1]) |
                 (rs2_used & (rs2 != '0) & busy_q[rs2]));
    end

    assign busy    = busy_q;
    assign err_waw = err_waw_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by writeback (fixed priority), load
// return and debug (round-robin between the latter two), plus load scoreboard.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned XLEN = RF_XLEN,
    parameter int unsigned NREG = RF_NREG,
    parameter int unsigned AW   = RF_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            ld_ready,
    input  logic            dbg_valid,
    input  logic [AW-1:0]   dbg_rd,
    input  logic [XLEN-1:0] dbg_data,
    output logic            dbg_ready,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic            rf_write,
    output logic [AW-1:0]   rf_writereg,
    output logic [XLEN-1:0] rf_writedata,
    output logic            stall,
    output logic [NREG-1:0] busy,
    output logic            err_waw
);

    req_e grant;
    rr_e  rr_ptr_d, rr_ptr_q;

    always_comb begin
        grant = REQ_NONE;
        if (!rst_n) begin
            grant = REQ_NONE;
        end else if (wb_valid) begin
            grant = REQ_WB;
        end else if (ld_valid && dbg_valid) begin
            grant = (rr_ptr_q == RR_LD) ? REQ_LD : REQ_DBG;
        end else if (ld_valid) begin
            grant = REQ_LD;
        end else if (dbg_valid) begin
            grant = REQ_DBG;
        end
    end

    always_comb begin
        rr_ptr_d = rr_next(grant, rr_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= RR_LD;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        rf_writereg  = '0;
        rf_writedata = '0;
        unique case (grant)
            REQ_WB: begin
                rf_writereg  = wb_rd;
                rf_writedata = wb_data;
            end
            REQ_LD: begin
                rf_writereg  = ld_rd;
                rf_writedata = ld_data;
            end
            REQ_DBG: begin
                rf_writereg  = dbg_rd;
                rf_writedata = dbg_data;
            end
            default: ;
        endcase
        // x0 requests are accepted but never reach the array.
        rf_write  = (grant != REQ_NONE) && (rf_writereg != '0);
        ld_ready  = (grant == REQ_LD);
        dbg_ready = (grant == REQ_DBG);
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (ld_issue),
        .set_idx  (ld_issue_rd),
        .clr_en   (ld_valid & ld_ready),
        .clr_idx  (ld_rd),
        .rs1      (rs1),
        .rs1_used (rs1_used),
        .rs2      (rs2),
        .rs2_used (rs2_used),
        .stall    (stall),
        .busy     (busy),
        .err_waw  (err_waw)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_rf_write_arbiter;

    localparam int G_NONE = 0;
    localparam int G_WB   = 1;
    localparam int G_LD   = 2;
    localparam int G_DBG  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, ld_valid, dbg_valid, ld_issue, rs1_used, rs2_used;
    logic [4:0]  wb_rd, ld_rd, dbg_rd, ld_issue_rd, rs1, rs2;
    logic [31:0] wb_data, ld_data, dbg_data;
    logic        ld_ready, dbg_ready, rf_write, stall, err_waw;
    logic [4:0]  rf_writereg;
    logic [31:0] rf_writedata;
    logic [31:0] busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    bit m_busy [32];
    bit m_ld_first;
    bit m_err;
    int last_g;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .ld_valid     (ld_valid),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .dbg_valid    (dbg_valid),
        .dbg_rd       (dbg_rd),
        .dbg_data     (dbg_data),
        .dbg_ready    (dbg_ready),
        .ld_issue     (ld_issue),
        .ld_issue_rd  (ld_issue_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .rf_write     (rf_write),
        .rf_writereg  (rf_writereg),
        .rf_writedata (rf_writedata),
        .stall        (stall),
        .busy         (busy),
        .err_waw      (err_waw)
    );

    function automatic int exp_grant();
        if (!rst_n) return G_NONE;
        if (wb_valid) return G_WB;
        if (ld_valid && dbg_valid) return m_ld_first ? G_LD : G_DBG;
        if (ld_valid) return G_LD;
        if (dbg_valid) return G_DBG;
        return G_NONE;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic exp_stall();
        if (!rst_n) return 1'b0;
        return (rs1_used && rs1 != 0 && m_busy[rs1]) || (rs2_used && rs2 != 0 && m_busy[rs2]);
    endfunction

    // Apply one clock edge to the model, then let the DUT take the same edge.
    task automatic advance();
        int g;
        g = exp_grant();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_ld_first = 1'b1;
            m_err      = 1'b0;
        end else begin
            if (ld_issue && m_busy[ld_issue_rd]) m_err = 1'b1;
            if (g == G_LD) m_busy[ld_rd] = 1'b0;
            if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
            if (g == G_LD) m_ld_first = 1'b0;
            if (g == G_DBG) m_ld_first = 1'b1;
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; ld_valid = 0; dbg_valid = 0; ld_issue = 0;
        rs1_used = 0; rs2_used = 0;
        wb_rd = 0; ld_rd = 0; dbg_rd = 0; ld_issue_rd = 0; rs1 = 0; rs2 = 0;
        wb_data = 0; ld_data = 0; dbg_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        wb_valid = 1; ld_valid = 1; dbg_valid = 1;
        wb_rd = 1; ld_rd = 2; dbg_rd = 3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++;
            if (rf_write !== 1'b0) begin
                n_fail++; $display("FAIL reset_rf_write: got %b want 0", rf_write);
            end
            n_checks++;
            if (ld_ready !== 1'b0 || dbg_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_ready: got ld=%b dbg=%b want 0/0", ld_ready, dbg_ready);
            end
            n_checks++;
            if (busy !== 32'h0 || stall !== 1'b0) begin
                n_fail++; $display("FAIL reset_busy: got busy=%h stall=%b want 0/0", busy, stall);
            end
            advance();
        end
        rst_n = 1; wb_valid = 0;
        @(negedge clk);
        n_checks++;
        if (ld_ready !== 1'b1 || dbg_ready !== 1'b0 || rf_writereg !== 5'd2) begin
            n_fail++;
            $display("FAIL reset_ld_first: got ld=%b dbg=%b reg=%0d want 1/0/2", ld_ready, dbg_ready, rf_writereg);
        end
        advance();
        ld_valid = 0;
        @(negedge clk);
        n_checks++;
        if (dbg_ready !== 1'b1 || rf_writereg !== 5'd3) begin
            n_fail++; $display("FAIL reset_dbg_next: got dbg=%b reg=%0d want 1/3", dbg_ready, rf_writereg);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_priority();
        logic [4:0] want_reg;
        wb_valid = 1; wb_rd = 5; wb_data = 32'hAAAA0001;
        ld_valid = 1; ld_rd = 6; ld_data = 32'h6666_0006;
        dbg_valid = 1; dbg_rd = 7; dbg_data = 32'h7777_0007;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rf_write !== 1'b1 || rf_writereg !== 5'd5 || rf_writedata !== 32'hAAAA0001) begin
                n_fail++;
                $display("FAIL prio_wb: got we=%b reg=%0d data=%h want 1/5/aaaa0001", rf_write, rf_writereg, rf_writedata);
            end
            n_checks++;
            if (ld_ready !== 1'b0 || dbg_ready !== 1'b0) begin
                n_fail++; $display("FAIL prio_ready: got ld=%b dbg=%b want 0/0", ld_ready, dbg_ready);
            end
            advance();
        end
        wb_valid = 0;
        for (int c = 0; c < 3; c++) begin
            want_reg = (c % 2 == 0) ? 5'd6 : 5'd7;
            @(negedge clk);
            n_checks++;
            if (rf_writereg !== want_reg || ld_ready !== (c % 2 == 0) || dbg_ready !== (c % 2 == 1)) begin
                n_fail++;
                $display("FAIL prio_alternate[%0d]: got reg=%0d ld=%b dbg=%b want reg=%0d", c, rf_writereg, ld_ready, dbg_ready, want_reg);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        ld_issue = 1; ld_issue_rd = 9;
        advance();
        ld_issue = 0;
        rs1 = 9; rs1_used = 1;
        @(negedge clk);
        n_checks++;
        if (busy[9] !== 1'b1 || stall !== 1'b1) begin
            n_fail++; $display("FAIL sb_set: got busy9=%b stall=%b want 1/1", busy[9], stall);
        end
        advance();
        ld_valid = 1; ld_rd = 9; ld_data = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if (ld_ready !== 1'b1 || stall !== 1'b1 || rf_writedata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL sb_return: got rdy=%b stall=%b data=%h want 1/1/12345678", ld_ready, stall, rf_writedata);
        end
        advance();
        ld_valid = 0;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b0 || busy[9] !== 1'b0) begin
            n_fail++; $display("FAIL sb_clear: got stall=%b busy9=%b want 0/0", stall, busy[9]);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_same_cycle_and_waw();
        ld_issue = 1; ld_issue_rd = 12;
        advance();
        n_checks++;
        if (err_waw !== 1'b0) begin
            n_fail++; $display("FAIL waw_clean: got %b want 0", err_waw);
        end
        ld_valid = 1; ld_rd = 12;
        @(negedge clk);
        n_checks++;
        if (ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_ready: got %b want 1", ld_ready);
        end
        advance();
        ld_valid = 0; ld_issue = 0;
        @(negedge clk);
        n_checks++;
        if (busy[12] !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_setwins: got busy12=%b want 1", busy[12]);
        end
        ld_issue = 1;
        advance();
        ld_issue = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (err_waw !== 1'b1) begin
                n_fail++; $display("FAIL waw_sticky[%0d]: got %b want 1", c, err_waw);
            end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_x0();
        dbg_valid = 1; dbg_rd = 0; dbg_data = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if (dbg_ready !== 1'b1 || rf_write !== 1'b0) begin
            n_fail++; $display("FAIL x0_dbg: got rdy=%b we=%b want 1/0", dbg_ready, rf_write);
        end
        advance();
        dbg_valid = 0; ld_issue = 1; ld_issue_rd = 0;
        advance();
        ld_issue = 0; rs2 = 0; rs2_used = 1;
        @(negedge clk);
        n_checks++;
        if (busy[0] !== 1'b0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL x0_busy: got busy0=%b stall=%b want 0/0", busy[0], stall);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        ld_issue = 1; ld_issue_rd = 3;
        advance();
        ld_issue = 0; rst_n = 0;
        advance();
        rst_n = 1;
        @(negedge clk);
        n_checks++;
        if (busy !== 32'h0 || err_waw !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%h err=%b want 0/0", busy, err_waw);
        end
        ld_valid = 1; ld_rd = 3;
        @(negedge clk);
        n_checks++;
        if (ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_late_ld: got %b want 1", ld_ready);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_random();
        int g;
        logic [4:0] wreg;
        logic [31:0] wdata;
        idle_inputs();
        last_g = G_NONE;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            wb_valid = ($urandom_range(0, 3) == 0);
            wb_rd = 5'($urandom_range(0, 31)); wb_data = $urandom;
            if (!ld_valid || last_g == G_LD) begin
                ld_valid = $urandom_range(0, 1) == 1;
                ld_rd = 5'($urandom_range(0, 31)); ld_data = $urandom;
            end
            if (!dbg_valid || last_g == G_DBG) begin
                dbg_valid = $urandom_range(0, 2) == 0;
                dbg_rd = 5'($urandom_range(0, 31)); dbg_data = $urandom;
            end
            ld_issue = $urandom_range(0, 2) == 0;
            ld_issue_rd = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
            rs1_used = $urandom_range(0, 1) == 1; rs2_used = $urandom_range(0, 1) == 1;
            @(negedge clk);
            g = exp_grant();
            wreg  = (g == G_WB) ? wb_rd : (g == G_LD) ? ld_rd : (g == G_DBG) ? dbg_rd : 5'd0;
            wdata = (g == G_WB) ? wb_data : (g == G_LD) ? ld_data : (g == G_DBG) ? dbg_data : 32'd0;
            n_checks++;
            if (ld_ready !== (g == G_LD) || dbg_ready !== (g == G_DBG)) begin
                n_fail++;
                $display("FAIL rnd_ready[%0d]: got ld=%b dbg=%b want grant=%0d", c, ld_ready, dbg_ready, g);
            end
            n_checks++;
            if (rf_write !== (wreg != 0) || rf_writereg !== wreg || rf_writedata !== wdata) begin
                n_fail++;
                $display("FAIL rnd_port[%0d]: got we=%b reg=%0d data=%h want %b/%0d/%h", c, rf_write, rf_writereg, rf_writedata, wreg != 0, wreg, wdata);
            end
            n_checks++;
            if (busy !== exp_busy() || err_waw !== m_err) begin
                n_fail++;
                $display("FAIL rnd_sb[%0d]: got busy=%h err=%b want %h/%b", c, busy, err_waw, exp_busy(), m_err);
            end
            n_checks++;
            if (stall !== exp_stall()) begin
                n_fail++; $display("FAIL rnd_stall[%0d]: got %b want %b", c, stall, exp_stall());
            end
            advance();
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_ld_first = 1'b1;
        m_err      = 1'b0;
        last_g     = G_NONE;
        test_reset();
        test_priority();
        test_scoreboard();
        test_same_cycle_and_waw();
        test_x0();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
